mem_ack_responder: RTL and testbench

MEM_ACK_RESPONDER -- requirements
Module: mem_ack_responder

---
 rtl/cache_pkg.sv | 23 ++
 rtl/resp_lat_counter.sv | 45 ++++
 rtl/mem_ack_responder.sv | 136 +++++++++++++
 tb/tb_mem_ack_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the memory acknowledge responder:
//   - state_t       : responder FSM states (IDLE, WAIT, ACK)
//   - DEF_ADDR_W    : default address width (16-entry store)
//   - DEF_DATA_W    : default data width
//   - DEF_LATENCY   : default capture-to-ack latency in clock edges
//   - CNT_W         : width of the latency down-counter (covers 0..15)
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LATENCY = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage : cache_pkg

// File: rtl/resp_lat_counter.sv
// -----------------------------------------------------------------------------
// resp_lat_counter
// Loadable down-counter that times the gap between request capture and ack.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (count -> 0)
//   i_load     : load i_load_val (has priority over decrement)
//   i_load_val : value to load
//   i_dec      : decrement by one
//   o_zero     : high when the count is zero
// -----------------------------------------------------------------------------
module resp_lat_counter
  import cache_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  // Count register: load wins over decrement; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_ZERO;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == CNT_ZERO);

endmodule : resp_lat_counter

// File: rtl/mem_ack_responder.sv
// -----------------------------------------------------------------------------
// mem_ack_responder
// Four-phase request/ack memory target backed by a small flop-array store.
// A request is captured only in IDLE; ack rises exactly LATENCY edges after
// the capture edge and falls on the first edge that sees both requests low.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (clears FSM, outputs and store)
//   memwr   : write request (level, held until ack)
//   memrd   : read request (level, held until ack); loses to memwr
//   addr    : request address
//   wdata   : write data
//   ack     : registered completion acknowledge
//   rdata   : registered read data, holds until the next read completes
//   busy    : high whenever the FSM is not IDLE
//   txn_cnt : completed-transaction counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module mem_ack_responder
  import cache_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memwr,
  input  logic              memrd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [7:0]        txn_cnt
);

  localparam int                 DEPTH    = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]   LOAD_VAL = CNT_W'(LATENCY - 1);
  localparam logic [DATA_W-1:0]  DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0]  ADDR_ZERO = {ADDR_W{1'b0}};

  state_t              r_state;
  logic                r_op_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic [7:0]          r_txn_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_req;
  logic                w_load;
  logic                w_dec;
  logic                w_zero;

  assign w_req  = memwr | memrd;
  assign w_load = (r_state == IDLE) && w_req;
  // Counter only runs down while waiting; at zero the FSM completes instead.
  assign w_dec  = (r_state == WAIT) && !w_zero;

  resp_lat_counter #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Responder FSM with capture registers, store, read data, ack and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op_wr   <= 1'b0;
      r_addr    <= ADDR_ZERO;
      r_wdata   <= DATA_ZERO;
      r_ack     <= 1'b0;
      r_rdata   <= DATA_ZERO;
      r_txn_cnt <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_ZERO;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            // Write wins when both requests are up.
            r_op_wr <= memwr;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_state <= WAIT;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          // Completion ignores the live request level: a dropped request
          // still produces a single-cycle ack.
          if (w_zero) begin
            if (r_op_wr) begin
              r_mem[r_addr] <= r_wdata;
            end else begin
              r_rdata <= r_mem[r_addr];
            end
            r_ack     <= 1'b1;
            r_txn_cnt <= r_txn_cnt + 8'd1;
            r_state   <= ACK;
          end else begin
            r_state <= WAIT;
          end
        end
        ACK: begin
          if (!w_req) begin
            r_ack   <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_ack   <= 1'b1;
            r_state <= ACK;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack     = r_ack;
  assign rdata   = r_rdata;
  assign txn_cnt = r_txn_cnt;
  assign busy    = (r_state != IDLE);

endmodule : mem_ack_responder

// File: tb/tb_mem_ack_responder.sv
module tb_mem_ack_responder;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       memwr = 1'b0;
  logic       memrd = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] wdata = 8'd0;
  logic       ack;
  logic [7:0] rdata;
  logic       busy;
  logic [7:0] txn_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: plain array store, last read value, completed count.
  logic [7:0] m_mem [16];
  logic [7:0] m_rdata;
  int         m_txn;

  mem_ack_responder #(
    .ADDR_W  (4),
    .DATA_W  (8),
    .LATENCY (LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .memwr   (memwr),
    .memrd   (memrd),
    .addr    (addr),
    .wdata   (wdata),
    .ack     (ack),
    .rdata   (rdata),
    .busy    (busy),
    .txn_cnt (txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'd0;
    m_rdata = 8'd0;
    m_txn   = 0;
  endtask

  // One full handshake. Called just after a rising edge with the DUT idle.
  task automatic do_txn(input bit wr, input bit rd, input logic [3:0] a,
                        input logic [7:0] d, input bit drop, input int hold);
    memwr = wr;
    memrd = rd;
    addr  = a;
    wdata = d;
    @(posedge clk); #1;                       // capture edge
    chk("busy_after_capture", 32'(busy), 1);
    chk("ack_at_capture", 32'(ack), 0);
    addr  = 4'($urandom);                     // post-capture changes must not matter
    wdata = 8'($urandom);
    if (drop) begin
      memwr = 1'b0;
      memrd = 1'b0;
    end
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk); #1;
      chk("ack_during_wait", 32'(ack), 0);
    end
    @(posedge clk); #1;                       // capture + LAT
    if (wr) m_mem[a] = d;
    else if (rd) m_rdata = m_mem[a];
    m_txn = (m_txn + 1) % 256;
    chk("ack_rise", 32'(ack), 1);
    chk("txn_cnt", 32'(txn_cnt), 32'(m_txn));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    if (!drop) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("ack_hold", 32'(ack), 1);
      end
      memwr = 1'b0;
      memrd = 1'b0;
    end
    @(posedge clk); #1;
    chk("ack_fall", 32'(ack), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    int op;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_txn", 32'(txn_cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle with no request: nothing happens
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_ack", 32'(ack), 0);
      chk("idle_busy", 32'(busy), 0);
    end

    // Directed: write 0xA5 to 3, read back twice (store unchanged by read)
    do_txn(1'b1, 1'b0, 4'd3, 8'hA5, 1'b0, 0);
    chk("first_txn_cnt", 32'(txn_cnt), 1);
    do_txn(1'b0, 1'b1, 4'd3, 8'h00, 1'b0, 2);
    chk("readback_a5", 32'(rdata), 32'h000000A5);
    do_txn(1'b0, 1'b1, 4'd3, 8'h00, 1'b0, 0);

    // Simultaneous request: write wins
    do_txn(1'b1, 1'b1, 4'd5, 8'h3C, 1'b0, 1);
    chk("both_rdata_kept", 32'(rdata), 32'h000000A5);
    do_txn(1'b0, 1'b1, 4'd5, 8'h00, 1'b0, 0);
    chk("readback_3c", 32'(rdata), 32'h0000003C);

    // Early drop during WAIT: single-cycle ack
    do_txn(1'b1, 1'b0, 4'd9, 8'h11, 1'b1, 0);
    do_txn(1'b0, 1'b1, 4'd9, 8'h00, 1'b1, 0);

    // Mid-operation reset: give addr 7 a value, then reset during a write to 7
    do_txn(1'b1, 1'b0, 4'd7, 8'h77, 1'b0, 0);
    memwr = 1'b1; addr = 4'd7; wdata = 8'h5A;
    @(posedge clk); #1;
    chk("pre_reset_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ack", 32'(ack), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_txn", 32'(txn_cnt), 0);
    chk("reset_rdata", 32'(rdata), 0);
    model_reset();
    memwr = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn(1'b0, 1'b1, 4'd7, 8'h00, 1'b0, 0);
    chk("read_after_reset", 32'(rdata), 0);
    do_txn(1'b0, 1'b1, 4'd3, 8'h00, 1'b0, 0);

    // Randomized traffic, 254 more transactions -> 256 since reset
    for (int n = 0; n < 254; n++) begin
      op = $urandom_range(0, 2);
      do_txn(op != 1, op != 0, 4'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    chk("txn_wrap", 32'(txn_cnt), 0);

    // One more read after wrap, checked against model
    do_txn(1'b0, 1'b1, 4'($urandom), 8'h00, 1'b0, 0);
    chk("txn_after_wrap", 32'(txn_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mem_ack_responder
